flt_mult_sched: RTL and testbench
=================================

Name: flt_mult_sched

Overview:
- Round-robin scheduler sharing one pipelined single-precision multiplier (flt_mult, 3-stage) among NREQ requesters.
- Accepts operand pairs over per-requester valid/ready handshakes and issues at most one pair per cycle to the multiplier.
- Tracks requester ID through a tag pipeline aligned to multiplier latency, and returns each product with its ID on a shared response bus.
- Sits between client engines and the flt_mult instance in the float datapath.

Parameters:
- NREQ, 4, number of requesters (2..8).
- MUL_LAT, 3, multiplier latency in clocks from operand sample to fl update.
- CNT_W, 16, width of the issue counter.

Ports:
- clk  in  1  clock; one clock domain for the whole block.
- rst  in  1  synchronous active-high reset.
- en  in  1  issue enable; low blocks new grants, in-flight ops still complete.
- req_valid  in  NREQ  per-requester operand-pair valid.
- req_ready  out  NREQ  per-requester accept (one-hot or zero).
- req_a  in  NREQ*32  operand A per requester; slice i = [32*i+31:32*i].
- req_b  in  NREQ*32  operand B per requester, same packing.
- mul_a  out  32  registered operand A to multiplier afl.
- mul_b  out  32  registered operand B to multiplier bfl.
- mul_fl  in  32  multiplier result fl.
- rsp_valid  out  1  response valid (single-cycle pulse per accepted request).
- rsp_id  out  $clog2(NREQ)  requester ID of the response.
- rsp_fl  out  32  product; equals mul_fl while rsp_valid is high.
- busy  out  1  high while any tag-pipeline entry is valid.
- issue_cnt  out  CNT_W  total accepted requests; wraps modulo 2^CNT_W.

Behaviour:
- Reset is synchronous and active-high. On reset:
  - mul_a = 0 and mul_b = 0.
  - All tag valids = 0; rsp_valid = 0, rsp_id = 0, busy = 0.
  - issue_cnt = 0.
  - Round-robin pointer last = NREQ-1, so requester 0 has first priority.
- Grant (combinational):
  - When en=1 and rst=0, grant the first i with req_valid[i]=1, searching last+1, last+2, … modulo NREQ.
  - req_ready = grant (one-hot). With en=0 or no valid request, req_ready = 0.
  - req_ready depends only on req_valid, en and internal state; never on req_a or req_b.
- Handshake: a transfer occurs on the rising edge when req_valid[i] and req_ready[i] are both high. A requester holds valid and data until accepted.
- On a transfer from requester i:
  - mul_a <= req_a slice i; mul_b <= req_b slice i.
  - Tag stage 0 <= {valid=1, id=i}; last <= i; issue_cnt <= issue_cnt + 1.
- No transfer: mul_a and mul_b load 0; tag stage 0 valid <= 0; last unchanged.
- Tag pipeline:
  - MUL_LAT+1 stages shifting every cycle.
  - rsp_valid and rsp_id are driven from the last stage, so a request accepted at edge T yields rsp_valid during the cycle after edge T+MUL_LAT (4 cycles after the accept cycle with default MUL_LAT).
  - rsp_fl = mul_fl, passed combinationally.
- Throughput:
  - One issue per cycle sustained; there is no backpressure on responses.
  - Consumers must accept rsp_valid pulses unconditionally.
- busy = OR of all tag valids.
- Fairness: with all NREQ requesters continuously valid, grants rotate 0,1,…,NREQ-1,0,… ; no requester waits more than NREQ-1 grants.
- Boundary conditions:
  - en falling with a request pending: no grant that cycle; the pending request stays unaccepted; in-flight responses still emerge.
  - Reset mid-operation: all tags are cleared, so in-flight products produce no rsp_valid even if mul_fl changes.
  - issue_cnt wraps from 2^CNT_W-1 to 0.
  - A requester dropping valid without being granted is legal; no state change results.

Decomposition:
- Shared package flt_pkg:
  - FLT_W = 32.
  - FLT_MULT_LAT = 3 (default for MUL_LAT).
  - FLT_ZERO = 32'h0.
  - Tag typedef {valid, id}.
- One natural sub-module: rr_arb (NREQ-wide round-robin grant from request vector and last pointer, combinational).
- Top contains the operand registers, tag pipeline and counter.
- The bench instantiates flt_mult behind flt_mult_sched.

Test Plan:
- Single request: req0 a=0x3F800000, b=0x40000000, accepted in cycle c → rsp_valid in cycle c+4, rsp_id=0, rsp_fl=0x40000000; issue_cnt=1; busy high cycles c+1..c+4.
- All 4 requesters continuously valid, req_i a=b=0x3FC00000 → grants 0,1,2,3,0,… one per cycle; rsp_valid high every cycle; every rsp_fl=0x40100000; IDs in grant order.
- Zero operand: req2 a=0x00000000, b=0x42280000 → rsp_id=2, rsp_fl=0x00000000.
- en=0 with req1 valid for 5 cycles → req_ready=0 and no new issues; in-flight responses still delivered; after en=1, req1 is granted the same cycle.
- Issue req0 and req1 in consecutive cycles, assert rst for 1 cycle two cycles later → no rsp_valid afterwards, busy=0, issue_cnt=0, mul_a=mul_b=0; next grant goes to requester 0.
- Pointer check: last grant = 3, then req1 and req3 valid → req1 granted first, then req3.

Source files
------------

// File: rtl/flt_pkg.sv
// flt_pkg: shared float datapath constants and the requester tag carried alongside multiplier ops.
package flt_pkg;
  localparam int FLT_W = 32;
  localparam int FLT_MULT_LAT = 3;
  localparam logic [FLT_W-1:0] FLT_ZERO = '0;
  localparam int TAG_ID_W = 3;
  typedef struct packed {
    logic valid;
    logic [TAG_ID_W-1:0] id;
  } tag_t;
endpackage

// File: rtl/flt_mult.sv
// flt_mult: 3-stage single-precision multiplier, denormals flushed to zero, mantissa truncated.
module flt_mult
  import flt_pkg::*;
(
  input  logic             clk,
  input  logic [FLT_W-1:0] afl,
  input  logic [FLT_W-1:0] bfl,
  output logic [FLT_W-1:0] fl
);
  logic s1_q, s1_d, z1_q, z1_d, s2_q, s2_d, z2_q, z2_d;
  logic [9:0] e1_q, e1_d, e2_q, e2_d;
  logic [47:0] p1_q, p1_d;
  logic [22:0] m2_q, m2_d;
  logic [FLT_W-1:0] fl_q, fl_d;
  logic unused_p;
  always_comb begin
    s1_d = afl[31] ^ bfl[31];
    z1_d = (afl[30:23] == 8'd0) || (bfl[30:23] == 8'd0);
    e1_d = 10'(afl[30:23]) + 10'(bfl[30:23]);
    p1_d = 48'({1'b1, afl[22:0]}) * 48'({1'b1, bfl[22:0]});
    s2_d = s1_q;
    z2_d = z1_q;
    e2_d = e1_q + 10'(p1_q[47]);
    m2_d = p1_q[47] ? p1_q[46:24] : p1_q[45:23];
    // biased exponent sum still carries one extra bias of 127
    fl_d = (z2_q || e2_q <= 10'd127) ? {s2_q, 31'b0} :
           (e2_q >= 10'd382)         ? {s2_q, 8'hff, 23'b0} :
                                       {s2_q, 8'(e2_q - 10'd127), m2_q};
  end
  always_ff @(posedge clk) begin
    s1_q <= s1_d;
    z1_q <= z1_d;
    e1_q <= e1_d;
    p1_q <= p1_d;
    s2_q <= s2_d;
    z2_q <= z2_d;
    e2_q <= e2_d;
    m2_q <= m2_d;
    fl_q <= fl_d;
  end
  assign unused_p = ^p1_q[22:0];
  assign fl = fl_q;
endmodule

// File: rtl/flt_mult_sched_rr_arb.sv
// rr_arb: combinational round-robin grant starting the search just after the last winner.
module rr_arb #(
  parameter int NREQ = 4,
  parameter int IW = $clog2(NREQ)
) (
  input  logic            en,
  input  logic [NREQ-1:0] req,
  input  logic [IW-1:0]   last,
  output logic [NREQ-1:0] gnt,
  output logic [IW-1:0]   gnt_idx,
  output logic            gnt_any
);
  localparam int SW = IW + 1;
  logic [SW-1:0] sum;
  logic [IW-1:0] idx;
  always_comb begin
    gnt = '0;
    gnt_idx = '0;
    gnt_any = 1'b0;
    sum = '0;
    idx = '0;
    // scan from farthest to nearest so the nearest requester wins
    for (int k = NREQ; k >= 1; k--) begin
      sum = {1'b0, last} + SW'(k);
      idx = IW'(sum >= SW'(NREQ) ? sum - SW'(NREQ) : sum);
      if (en && req[idx]) begin
        gnt_idx = idx;
        gnt_any = 1'b1;
      end
    end
    gnt[gnt_idx] = gnt_any;
  end
endmodule

// File: rtl/flt_mult_sched.sv
// flt_mult_sched: round-robin sharing of one pipelined multiplier among NREQ requesters,
// with a tag pipeline returning each product alongside its requester ID.
module flt_mult_sched
  import flt_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int MUL_LAT = FLT_MULT_LAT,
  parameter int CNT_W = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    en,
  input  logic [NREQ-1:0]         req_valid,
  output logic [NREQ-1:0]         req_ready,
  input  logic [NREQ*FLT_W-1:0]   req_a,
  input  logic [NREQ*FLT_W-1:0]   req_b,
  output logic [FLT_W-1:0]        mul_a,
  output logic [FLT_W-1:0]        mul_b,
  input  logic [FLT_W-1:0]        mul_fl,
  output logic                    rsp_valid,
  output logic [$clog2(NREQ)-1:0] rsp_id,
  output logic [FLT_W-1:0]        rsp_fl,
  output logic                    busy,
  output logic [CNT_W-1:0]        issue_cnt
);
  localparam int IW = $clog2(NREQ);
  logic [FLT_W-1:0] a_arr [NREQ];
  logic [FLT_W-1:0] b_arr [NREQ];
  logic [FLT_W-1:0] mul_a_q, mul_a_d, mul_b_q, mul_b_d;
  logic [IW-1:0] last_q, last_d, gnt_idx;
  logic gnt_any;
  tag_t tag_q [MUL_LAT+1];
  tag_t tag_d [MUL_LAT+1];
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic unused_id;
  for (genvar i = 0; i < NREQ; i++) begin : g_unpack
    assign a_arr[i] = req_a[FLT_W*i +: FLT_W];
    assign b_arr[i] = req_b[FLT_W*i +: FLT_W];
  end
  rr_arb #(.NREQ(NREQ)) u_arb (
    .en      (en & ~rst),
    .req     (req_valid),
    .last    (last_q),
    .gnt     (req_ready),
    .gnt_idx (gnt_idx),
    .gnt_any (gnt_any)
  );
  always_comb begin
    mul_a_d = gnt_any ? a_arr[gnt_idx] : FLT_ZERO;
    mul_b_d = gnt_any ? b_arr[gnt_idx] : FLT_ZERO;
    tag_d[0] = '{valid: gnt_any, id: TAG_ID_W'(gnt_idx)};
    for (int k = 1; k <= MUL_LAT; k++) tag_d[k] = tag_q[k-1];
    last_d = gnt_any ? gnt_idx : last_q;
    cnt_d = cnt_q + CNT_W'(gnt_any);
    busy = 1'b0;
    for (int k = 0; k <= MUL_LAT; k++) busy = busy | tag_q[k].valid;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      mul_a_q <= FLT_ZERO;
      mul_b_q <= FLT_ZERO;
      tag_q <= '{default: '0};
      last_q <= IW'(NREQ - 1);
      cnt_q <= '0;
    end else begin
      mul_a_q <= mul_a_d;
      mul_b_q <= mul_b_d;
      tag_q <= tag_d;
      last_q <= last_d;
      cnt_q <= cnt_d;
    end
  end
  assign mul_a = mul_a_q;
  assign mul_b = mul_b_q;
  assign rsp_valid = tag_q[MUL_LAT].valid;
  assign rsp_id = tag_q[MUL_LAT].id[IW-1:0];
  assign rsp_fl = mul_fl;
  assign issue_cnt = cnt_q;
  assign unused_id = ^tag_q[MUL_LAT].id;
endmodule

// File: tb/tb_flt_mult_sched.sv
// tb_flt_mult_sched: scheduler plus multiplier; accepted requests queue expected products,
// a negedge monitor pops and compares each response.
module tb_flt_mult_sched;
  logic clk = 1'b0, rst, en;
  logic [3:0] req_valid, req_ready;
  logic [127:0] req_a, req_b;
  logic [31:0] mul_a, mul_b, mul_fl, rsp_fl;
  logic rsp_valid, busy;
  logic [1:0] rsp_id;
  logic [15:0] issue_cnt;
  typedef struct {
    int id;
    logic [31:0] fl;
    int cyc;
  } exp_t;
  exp_t sb [$];
  exp_t mon_e;
  logic [31:0] exp_fl [4];
  int cyc = 0, tests = 0, fails = 0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  flt_mult_sched dut (
    .clk(clk), .rst(rst), .en(en), .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b), .mul_a(mul_a), .mul_b(mul_b), .mul_fl(mul_fl),
    .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_fl(rsp_fl), .busy(busy), .issue_cnt(issue_cnt)
  );
  flt_mult u_mul (.clk(clk), .afl(mul_a), .bfl(mul_b), .fl(mul_fl));
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic set_req(input int i, input logic [31:0] a, input logic [31:0] b, input logic [31:0] e);
    req_a[32*i +: 32] = a;
    req_b[32*i +: 32] = b;
    exp_fl[i] = e;
    req_valid[i] = 1'b1;
  endtask
  task automatic drain();
    for (int k = 0; k < 20 && sb.size() != 0; k++) tick();
    tick();
    chk("drain_empty", sb.size(), 0);
  endtask
  always @(negedge clk) begin
    for (int i = 0; i < 4; i++)
      if (req_valid[i] && req_ready[i]) sb.push_back('{id: i, fl: exp_fl[i], cyc: cyc + 4});
    if (req_ready != 4'd0) chk("ready_onehot", 32'($onehot(req_ready)), 1);
    if (rsp_valid) begin
      if (sb.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL rsp_unexpected: got id %0d fl %h, expected no response", rsp_id, rsp_fl);
      end else begin
        mon_e = sb.pop_front();
        chk("rsp_id", 32'(rsp_id), mon_e.id);
        chk("rsp_fl", rsp_fl, mon_e.fl);
        chk("rsp_cycle", cyc, mon_e.cyc);
      end
    end
  end
  initial begin
    rst = 1'b1; en = 1'b1; req_valid = '0; req_a = '0; req_b = '0;
    for (int i = 0; i < 4; i++) exp_fl[i] = '0;
    tick(); tick();
    chk("rst_mul_a", mul_a, 0);
    chk("rst_mul_b", mul_b, 0);
    chk("rst_rsp_valid", 32'(rsp_valid), 0);
    chk("rst_rsp_id", 32'(rsp_id), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_cnt", 32'(issue_cnt), 0);
    set_req(0, 32'h3F800000, 32'h40000000, 32'h40000000);
    #1 chk("rst_blocks_ready", 32'(req_ready), 0);
    rst = 1'b0;
    #1 chk("single_ready", 32'(req_ready), 1);
    tick();
    req_valid = '0;
    chk("single_cnt", 32'(issue_cnt), 1);
    chk("single_busy_c1", 32'(busy), 1);
    chk("single_mul_a", mul_a, 32'h3F800000);
    chk("single_mul_b", mul_b, 32'h40000000);
    tick(); tick();
    chk("single_busy_c3", 32'(busy), 1);
    tick();
    chk("single_busy_c4", 32'(busy), 1);
    chk("single_rsp_valid", 32'(rsp_valid), 1);
    tick();
    chk("single_busy_c5", 32'(busy), 0);
    chk("single_rsp_done", 32'(rsp_valid), 0);
    chk("single_mul_a_idle", mul_a, 0);
    // last winner is 0, so rotation starts at 1
    for (int i = 0; i < 4; i++) set_req(i, 32'h3FC00000, 32'h3FC00000, 32'h40100000);
    for (int k = 0; k < 12; k++) begin
      #1 chk("rr_ready", 32'(req_ready), 1 << ((k + 1) % 4));
      if (k >= 4) chk("rr_rsp_valid", 32'(rsp_valid), 1);
      tick();
    end
    req_valid = '0;
    drain();
    chk("rr_cnt", 32'(issue_cnt), 13);
    set_req(2, 32'h00000000, 32'h42280000, 32'h00000000);
    #1 chk("zero_ready", 32'(req_ready), 4);
    tick();
    req_valid = '0;
    drain();
    chk("zero_cnt", 32'(issue_cnt), 14);
    set_req(3, 32'h3F800000, 32'h40000000, 32'h40000000);
    #1 chk("en_pre_ready", 32'(req_ready), 8);
    tick();
    req_valid = '0;
    en = 1'b0;
    set_req(1, 32'h40000000, 32'h40400000, 32'h40C00000);
    for (int k = 0; k < 5; k++) begin
      req_valid[1] = (k != 2);
      #1 chk("en_low_ready", 32'(req_ready), 0);
      chk("en_low_cnt", 32'(issue_cnt), 15);
      chk("en_low_inflight", 32'(rsp_valid), 32'(k == 3));
      tick();
    end
    en = 1'b1;
    #1 chk("en_high_ready", 32'(req_ready), 2);
    tick();
    req_valid = '0;
    drain();
    chk("en_cnt", 32'(issue_cnt), 16);
    set_req(3, 32'h3FC00000, 32'h3FC00000, 32'h40100000);
    #1 chk("ptr_setup_ready", 32'(req_ready), 8);
    tick();
    req_valid = '0;
    set_req(1, 32'h3F800000, 32'h40000000, 32'h40000000);
    set_req(3, 32'h3FC00000, 32'h3FC00000, 32'h40100000);
    #1 chk("ptr_first", 32'(req_ready), 2);
    tick();
    req_valid[1] = 1'b0;
    #1 chk("ptr_second", 32'(req_ready), 8);
    tick();
    req_valid = '0;
    drain();
    chk("ptr_cnt", 32'(issue_cnt), 19);
    set_req(0, 32'h3F800000, 32'h40000000, 32'h40000000);
    #1 chk("mid_ready0", 32'(req_ready), 1);
    tick();
    req_valid = '0;
    set_req(1, 32'h3F800000, 32'h40000000, 32'h40000000);
    #1 chk("mid_ready1", 32'(req_ready), 2);
    tick();
    req_valid = '0;
    tick();
    rst = 1'b1;
    sb.delete();
    tick();
    rst = 1'b0;
    #1 chk("mid_busy", 32'(busy), 0);
    chk("mid_cnt", 32'(issue_cnt), 0);
    chk("mid_mul_a", mul_a, 0);
    chk("mid_mul_b", mul_b, 0);
    for (int k = 0; k < 5; k++) begin
      chk("mid_no_rsp", 32'(rsp_valid), 0);
      tick();
    end
    set_req(2, 32'h00000000, 32'h42280000, 32'h00000000);
    set_req(0, 32'h3F800000, 32'h40000000, 32'h40000000);
    #1 chk("post_rst_ready", 32'(req_ready), 1);
    tick();
    req_valid[0] = 1'b0;
    #1 chk("post_rst_next", 32'(req_ready), 4);
    tick();
    req_valid = '0;
    chk("post_rst_cnt", 32'(issue_cnt), 2);
    for (int i = 0; i < 4; i++) set_req(i, 32'h3FC00000, 32'h3FC00000, 32'h40100000);
    for (int k = 0; k < 65533; k++) tick();
    chk("cnt_max", 32'(issue_cnt), 32'hFFFF);
    tick();
    chk("cnt_wrap", 32'(issue_cnt), 0);
    req_valid = '0;
    drain();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
